// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the clock-divider computation used by both the rx and tx tick generators.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clock cycles per sample tick, truncated by integer division.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Sample-tick generator: a one-cycle pulse every DIV clocks while enabled.
// The counter sits at zero while disabled, so the first tick always lands
// exactly DIV cycles after enable rises.
module uart_rx_tick #(
    parameter int DIV = 13
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and tick strobe.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = CW'(cnt_q + 1'b1);
        end
    end

    // Divider counter register.
    // NOTE: sequential state is assigned with <= only, so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. Bits are sampled at their middle,
// bytes are delivered LSB first with a one-cycle rx_valid strobe, and a low
// stop bit raises rx_frame_err and parks the FSM until the line goes idle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_freq = 24000000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int DIV = calc_div(clk_freq, baud);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx: clk_freq too low for baud * OVERSAMPLE (DIV < 1)");
        end
    endgenerate

    rx_state_e   state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [3:0]  sample_q, sample_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        tick;

    uart_rx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .enable (state_q != ST_IDLE),
        .tick   (tick)
    );

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state, sampling and output-strobe logic.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d  = ST_START;
                    sample_d = '0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (sample_q == 4'd7) begin
                        // Mid start bit: a high line here was only a glitch.
                        state_d  = rx_s_q ? ST_IDLE : ST_DATA;
                        sample_d = '0;
                        bit_d    = '0;
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d  = ST_STOP;
                            sample_d = '0;
                        end
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == 4'd15) begin
                        sample_d = '0;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end
                end
            end

            ST_BREAK: begin
                // Hold off until the line returns high so a long low level
                // cannot be taken as a fresh start bit.
                if (rx_s_q) begin
                    state_d  = ST_IDLE;
                    sample_d = '0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                sample_d = '0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: serial frames are driven in real time, expected
// events (good byte or framing error) are queued by the bench, and a
// negedge monitor matches every strobe from the receiver against the queue.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam realtime CLK_PERIOD = 10.0;
    localparam realtime BIT_TIME   = 320.0;   // 32 clocks at DIV=2

    logic       clk;
    logic       resetn;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       ev;
    logic [7:0] model_data;
    logic [7:0] prev_data;
    logic       prev_busy;
    int         n_valid;
    int         n_ferr;
    int         n_checks;
    int         n_errors;

    uart_rx #(
        .clk_freq (3200000),
        .baud     (100000)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one 8N1 frame, LSB first; the line is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] d, input logic stop, input realtime bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bt);
        end
        rx = stop;
        #(bt);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_q.push_back('{is_err: 1'b0, data: d});
    endtask

    task automatic expect_err();
        exp_q.push_back('{is_err: 1'b1, data: 8'h00});
    endtask

    // Event monitor: matches each strobe with the next queued expectation.
    always @(negedge clk) begin
        if (resetn) begin
            if (rx_valid || rx_frame_err) begin
                check("one_strobe", 32'(rx_valid & rx_frame_err), 32'd0);
                check("event_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("event_kind", 32'(rx_frame_err), 32'(ev.is_err));
                    if (rx_valid && !ev.is_err) begin
                        check("rx_data", 32'(rx_data), 32'(ev.data));
                        model_data = ev.data;
                    end
                end
            end
            if (rx_valid) begin
                n_valid++;
                check("busy_at_valid", 32'(rx_busy), 32'd0);
                check("busy_before_valid", 32'(prev_busy), 32'd1);
            end
            if (rx_frame_err) begin
                n_ferr++;
                check("data_hold_on_err", 32'(rx_data), 32'(model_data));
            end
            if (!rx_valid && rx_data != prev_data) begin
                check("data_stable", 32'(rx_data), 32'(prev_data));
            end
        end
        prev_busy = rx_busy;
        prev_data = rx_data;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0;
        logic [7:0] d;
        int bt_i, gap;

        n_valid    = 0;
        n_ferr     = 0;
        n_checks   = 0;
        n_errors   = 0;
        model_data = 8'h00;
        prev_data  = 8'h00;
        prev_busy  = 1'b0;
        rx         = 1'b1;
        resetn     = 1'b0;

        #22;
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ferr", 32'(rx_frame_err), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        #10;
        resetn = 1'b1;
        #200;

        // Single good frame.
        v0 = n_valid; f0 = n_ferr;
        expect_byte(8'hA5);
        send_byte(8'hA5, 1'b1, BIT_TIME);
        #(BIT_TIME);
        check("a5_valid_count", 32'(n_valid - v0), 32'd1);
        check("a5_ferr_count", 32'(n_ferr - f0), 32'd0);
        check("a5_data", 32'(rx_data), 32'hA5);

        // Back-to-back frames with no idle gap.
        v0 = n_valid; f0 = n_ferr;
        expect_byte(8'h00);
        expect_byte(8'hFF);
        expect_byte(8'h55);
        send_byte(8'h00, 1'b1, BIT_TIME);
        send_byte(8'hFF, 1'b1, BIT_TIME);
        send_byte(8'h55, 1'b1, BIT_TIME);
        #(BIT_TIME);
        check("b2b_valid_count", 32'(n_valid - v0), 32'd3);
        check("b2b_ferr_count", 32'(n_ferr - f0), 32'd0);
        check("b2b_data", 32'(rx_data), 32'h55);

        // 12-cycle glitch on an idle line.
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        #(8 * CLK_PERIOD);
        check("glitch_busy", 32'(rx_busy), 32'd1);
        #(4 * CLK_PERIOD);
        rx = 1'b1;
        #(2 * BIT_TIME);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        check("glitch_valid_count", 32'(n_valid - v0), 32'd0);
        check("glitch_ferr_count", 32'(n_ferr - f0), 32'd0);
        check("glitch_data", 32'(rx_data), 32'h55);

        // Framing error, long break, then a good frame.
        v0 = n_valid; f0 = n_ferr;
        expect_err();
        send_byte(8'h3C, 1'b0, BIT_TIME);
        #(2.5 * BIT_TIME);
        check("break_busy", 32'(rx_busy), 32'd1);
        check("break_data", 32'(rx_data), 32'h55);
        #(2.5 * BIT_TIME);
        rx = 1'b1;
        #(2 * BIT_TIME);
        check("break_released", 32'(rx_busy), 32'd0);
        expect_byte(8'h81);
        send_byte(8'h81, 1'b1, BIT_TIME);
        #(BIT_TIME);
        check("ferr_count", 32'(n_ferr - f0), 32'd1);
        check("ferr_valid_count", 32'(n_valid - v0), 32'd1);
        check("after_break_data", 32'(rx_data), 32'h81);

        // Reset in the middle of data bit 4 of 0x77.
        d = 8'h77;
        rx = 1'b0;
        #(BIT_TIME);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            #(BIT_TIME);
        end
        rx = d[4];
        #(BIT_TIME / 2 + 3);
        resetn = 1'b0;
        exp_q.delete();
        model_data = 8'h00;
        #1;
        check("midrst_data", 32'(rx_data), 32'h00);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_ferr", 32'(rx_frame_err), 32'd0);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        rx = 1'b1;
        #(BIT_TIME);
        resetn = 1'b1;
        #(BIT_TIME);
        v0 = n_valid;
        expect_byte(8'h12);
        send_byte(8'h12, 1'b1, BIT_TIME);
        #(BIT_TIME);
        check("postrst_valid_count", 32'(n_valid - v0), 32'd1);
        check("postrst_data", 32'(rx_data), 32'h12);

        // Bit period stretched and shrunk by 2%.
        expect_byte(8'hC3);
        send_byte(8'hC3, 1'b1, BIT_TIME * 1.02);
        #(BIT_TIME);
        check("slow_data", 32'(rx_data), 32'hC3);
        model_data = 8'h00;
        expect_byte(8'h3C);
        send_byte(8'h3C, 1'b1, BIT_TIME);
        #(BIT_TIME);
        expect_byte(8'hC3);
        send_byte(8'hC3, 1'b1, BIT_TIME * 0.98);
        #(BIT_TIME);
        check("fast_data", 32'(rx_data), 32'hC3);

        // Random bytes, random bit period within tolerance, random gaps.
        v0 = n_valid; f0 = n_ferr;
        for (int k = 0; k < 12; k++) begin
            d    = 8'($urandom_range(0, 255));
            bt_i = 314 + $urandom_range(0, 12);
            gap  = $urandom_range(0, 60);
            expect_byte(d);
            send_byte(d, 1'b1, realtime'(bt_i));
            #(gap);
        end
        #(2 * BIT_TIME);
        check("rand_valid_count", 32'(n_valid - v0), 32'd12);
        check("rand_ferr_count", 32'(n_ferr - f0), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(rx_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
